// File: rtl/riscv_csr_pkg.sv
// Shared definitions for the machine-mode CSR unit: CSR addresses, access
// opcodes, mstatus field positions and standard mcause codes.
package riscv_csr_pkg;

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MISA      = 12'h301;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MTVAL     = 12'h343;
  localparam logic [11:0] CSR_MIP       = 12'h344;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_CYCLE     = 12'hC00;
  localparam logic [11:0] CSR_INSTRET   = 12'hC02;
  localparam logic [11:0] CSR_MVENDORID = 12'hF11;
  localparam logic [11:0] CSR_MARCHID   = 12'hF12;
  localparam logic [11:0] CSR_MIMPID    = 12'hF13;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;

  typedef enum logic [1:0] {
    CSR_NONE = 2'b00,
    CSR_RW   = 2'b01,
    CSR_RS   = 2'b10,
    CSR_RC   = 2'b11
  } csr_op_t;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

  localparam int CAUSE_INSN_MISALIGNED = 0;
  localparam int CAUSE_ILLEGAL_INSN    = 2;
  localparam int CAUSE_BREAKPOINT      = 3;
  localparam int CAUSE_ECALL_M         = 11;
  localparam int CAUSE_M_TIMER_IRQ     = 7;
  localparam int CAUSE_M_EXT_IRQ       = 11;

endpackage

// File: rtl/riscv_iss_csr_counter.sv
// Free-running XLEN-bit counter; a direct write overrides the increment.
module riscv_iss_csr_counter #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            inc,
  input  logic            we,
  input  logic [XLEN-1:0] wd,
  output logic [XLEN-1:0] count
);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   count <= '0;
    else if (we)  count <= wd;
    else if (inc) count <= count + XLEN'(1);
  end

endmodule

// File: rtl/riscv_iss_mcsr.sv
// Machine-mode CSR unit: CSR read-modify-write, illegal-access detection,
// mcycle/minstret, trap entry / MRET and trap-vector generation.
module riscv_iss_mcsr
  import riscv_csr_pkg::*;
#(
  parameter int              XLEN        = 64,
  parameter int              HARTID      = 0,
  parameter logic [XLEN-1:0] MTVEC_RESET = '0,
  parameter logic [63:0]     MISA_VAL    = 64'h8000_0000_0014_112D
) (
  input  logic            CLK,
  input  logic            RSTn,
  input  logic            CSR_EN,
  input  logic [1:0]      CSR_OP,
  input  logic [11:0]     A,
  input  logic [XLEN-1:0] WD,
  output logic [XLEN-1:0] RD,
  output logic            ILLEGAL,
  input  logic            RETIRE,
  input  logic            TRAP,
  input  logic [XLEN-1:0] TRAP_CAUSE,
  input  logic [XLEN-1:0] TRAP_PC,
  input  logic [XLEN-1:0] TRAP_VAL,
  input  logic            MRET,
  output logic [XLEN-1:0] trap_vec,
  output logic [XLEN-1:0] mepc,
  output logic            mie_g
);

  csr_op_t         op;
  logic            st_mie, st_mpie;
  logic [XLEN-1:0] mie_q, mtvec_q, mscratch_q, mepc_q, mcause_q, mtval_q;
  logic [XLEN-1:0] mcycle_q, minstret_q;
  logic [XLEN-1:0] rd_val, wval, base, cause_idx;
  logic            hit, wr_attempt, csr_we;

  assign op = csr_op_t'(CSR_OP);

  // NOTE: every variable driven here gets a default first, so no path through
  // the case leaves it unassigned and no latch is inferred.
  always_comb begin
    rd_val = '0;
    hit    = 1'b1;
    case (A)
      CSR_MSTATUS: begin
        rd_val[MSTATUS_MIE]                   = st_mie;
        rd_val[MSTATUS_MPIE]                  = st_mpie;
        rd_val[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
      end
      CSR_MISA:                 rd_val = MISA_VAL[XLEN-1:0];
      CSR_MIE:                  rd_val = mie_q;
      CSR_MTVEC:                rd_val = mtvec_q;
      CSR_MSCRATCH:             rd_val = mscratch_q;
      CSR_MEPC:                 rd_val = mepc_q;
      CSR_MCAUSE:               rd_val = mcause_q;
      CSR_MTVAL:                rd_val = mtval_q;
      CSR_MCYCLE, CSR_CYCLE:    rd_val = mcycle_q;
      CSR_MINSTRET, CSR_INSTRET: rd_val = minstret_q;
      CSR_MHARTID:              rd_val = XLEN'(HARTID);
      CSR_MIP, CSR_MVENDORID, CSR_MARCHID, CSR_MIMPID: rd_val = '0;
      default:                  hit = 1'b0;
    endcase
  end

  assign RD = rd_val;

  // Set/clear with a zero mask is a pure read and never counts as a write.
  assign wr_attempt = (op == CSR_RW) || ((op == CSR_RS || op == CSR_RC) && (WD != '0));
  assign ILLEGAL    = CSR_EN && (!hit || (op == CSR_NONE) ||
                                 (wr_attempt && (A[11:10] == 2'b11)));
  assign csr_we     = CSR_EN && !ILLEGAL && wr_attempt && !TRAP && !MRET;

  always_comb begin
    wval = rd_val;
    case (op)
      CSR_RW:  wval = WD;
      CSR_RS:  wval = rd_val | WD;
      CSR_RC:  wval = rd_val & ~WD;
      default: wval = rd_val;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      st_mie     <= 1'b0;
      st_mpie    <= 1'b0;
      mie_q      <= '0;
      mtvec_q    <= MTVEC_RESET;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mtval_q    <= '0;
    end else if (TRAP) begin
      mepc_q   <= {TRAP_PC[XLEN-1:2], 2'b00};
      mcause_q <= TRAP_CAUSE;
      mtval_q  <= TRAP_VAL;
      st_mpie  <= st_mie;
      st_mie   <= 1'b0;
    end else if (MRET) begin
      st_mie  <= st_mpie;
      st_mpie <= 1'b1;
    end else if (csr_we) begin
      case (A)
        CSR_MSTATUS: begin
          st_mie  <= wval[MSTATUS_MIE];
          st_mpie <= wval[MSTATUS_MPIE];
        end
        CSR_MIE:      mie_q      <= wval;
        // Reserved modes 2/3 collapse to direct mode.
        CSR_MTVEC:    mtvec_q    <= {wval[XLEN-1:2], wval[1] ? 2'b00 : wval[1:0]};
        CSR_MSCRATCH: mscratch_q <= wval;
        CSR_MEPC:     mepc_q     <= {wval[XLEN-1:2], 2'b00};
        CSR_MCAUSE:   mcause_q   <= wval;
        CSR_MTVAL:    mtval_q    <= wval;
        default: ;
      endcase
    end
  end

  riscv_iss_csr_counter #(.XLEN(XLEN)) u_mcycle (
    .clk   (CLK),
    .rst_n (RSTn),
    .inc   (1'b1),
    .we    (csr_we && (A == CSR_MCYCLE)),
    .wd    (wval),
    .count (mcycle_q)
  );

  riscv_iss_csr_counter #(.XLEN(XLEN)) u_minstret (
    .clk   (CLK),
    .rst_n (RSTn),
    .inc   (RETIRE),
    .we    (csr_we && (A == CSR_MINSTRET)),
    .wd    (wval),
    .count (minstret_q)
  );

  assign base      = {mtvec_q[XLEN-1:2], 2'b00};
  assign cause_idx = {1'b0, TRAP_CAUSE[XLEN-2:0]};
  assign trap_vec  = (mtvec_q[1:0] == 2'b01 && TRAP_CAUSE[XLEN-1])
                   ? base + (cause_idx << 2) : base;

  assign mepc  = mepc_q;
  assign mie_g = st_mie;

endmodule

// File: tb/tb_riscv_iss_mcsr.sv
// Directed bench for riscv_iss_mcsr: expectations are queued as stimulus is
// applied and popped against the combinational outputs mid-cycle.
module tb_riscv_iss_mcsr;
  import riscv_csr_pkg::*;

  localparam int          XLEN  = 64;
  localparam logic [63:0] MTVEC = 64'h100;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            csr_en, retire, trap, mret;
  logic [1:0]      csr_op;
  logic [11:0]     a;
  logic [XLEN-1:0] wd, rd, trap_cause, trap_pc, trap_val, trap_vec, mepc;
  logic            illegal, mie_g;

  riscv_iss_mcsr #(
    .XLEN(XLEN), .HARTID(3), .MTVEC_RESET(MTVEC), .MISA_VAL(64'h8000_0000_0014_112D)
  ) dut (
    .CLK(clk), .RSTn(rst_n), .CSR_EN(csr_en), .CSR_OP(csr_op), .A(a), .WD(wd),
    .RD(rd), .ILLEGAL(illegal), .RETIRE(retire), .TRAP(trap),
    .TRAP_CAUSE(trap_cause), .TRAP_PC(trap_pc), .TRAP_VAL(trap_val), .MRET(mret),
    .trap_vec(trap_vec), .mepc(mepc), .mie_g(mie_g)
  );

  always #5 clk = ~clk;

  typedef enum {SIG_RD, SIG_ILL, SIG_TVEC, SIG_MEPC, SIG_MIEG} sig_e;
  typedef struct {
    string       tag;
    sig_e        sig;
    logic [63:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic expect_val(input string tag, input sig_e sig, input logic [63:0] val);
    sb.push_back('{tag, sig, val});
  endtask

  task automatic check();
    exp_t        e;
    logic [63:0] obs;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.sig)
        SIG_RD:   obs = rd;
        SIG_ILL:  obs = {63'b0, illegal};
        SIG_TVEC: obs = trap_vec;
        SIG_MEPC: obs = mepc;
        default:  obs = {63'b0, mie_g};
      endcase
      n_cmp++;
      assert (obs === e.val) else begin
        n_err++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
      end
    end
  endtask

  // One cycle slot: controls cleared just after the edge, then re-driven.
  task automatic slot();
    @(posedge clk);
    #1;
    csr_en = 1'b0; csr_op = 2'b00; retire = 1'b0; trap = 1'b0; mret = 1'b0;
  endtask

  task automatic acc(input csr_op_t op, input logic [11:0] addr, input logic [63:0] data);
    slot();
    csr_en = 1'b1; csr_op = op; a = addr; wd = data;
    #1;
  endtask

  task automatic rd_chk(input string tag, input logic [11:0] addr, input logic [63:0] exp_v);
    acc(CSR_RS, addr, 64'h0);
    expect_val(tag, SIG_RD, exp_v);
    expect_val({tag, "_ill"}, SIG_ILL, 64'h0);
    check();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; csr_en = 1'b0; csr_op = 2'b00; a = '0; wd = '0;
    retire = 1'b0; trap = 1'b0; mret = 1'b0;
    trap_cause = '0; trap_pc = '0; trap_val = '0;
    repeat (3) @(negedge clk);
    expect_val("rst_mepc", SIG_MEPC, 64'h0);
    expect_val("rst_mieg", SIG_MIEG, 64'h0);
    expect_val("rst_tvec", SIG_TVEC, MTVEC);
    check();
    rst_n = 1'b1;

    rd_chk("hartid", CSR_MHARTID, 64'd3);
    rd_chk("mtvec_rst", CSR_MTVEC, MTVEC);
    rd_chk("misa", CSR_MISA, 64'h8000_0000_0014_112D);
    acc(CSR_RS, 12'h7C0, 64'h0);
    expect_val("unimpl_ill", SIG_ILL, 64'h1); check();
    acc(CSR_NONE, CSR_MSCRATCH, 64'h0);
    expect_val("opnone_ill", SIG_ILL, 64'h1); check();

    // Read-modify-write sequence on mscratch.
    acc(CSR_RW, CSR_MSCRATCH, 64'h1234);
    expect_val("rw_old", SIG_RD, 64'h0); expect_val("rw_ill", SIG_ILL, 64'h0); check();
    acc(CSR_RS, CSR_MSCRATCH, 64'hF0000);
    expect_val("rs_old", SIG_RD, 64'h1234); check();
    acc(CSR_RC, CSR_MSCRATCH, 64'h4);
    expect_val("rc_old", SIG_RD, 64'hF1234); check();
    rd_chk("rc_new", CSR_MSCRATCH, 64'hF1230);
    rd_chk("rs0_keep", CSR_MSCRATCH, 64'hF1230);

    // Counters: write precedence, read-only aliases, wrap.
    acc(CSR_RW, CSR_MCYCLE, 64'd100);
    acc(CSR_RW, CSR_CYCLE, 64'd5);
    expect_val("cyc_wr_ill", SIG_ILL, 64'h1);
    expect_val("cyc_wr_rd", SIG_RD, 64'd100); check();
    rd_chk("cyc_alias", CSR_CYCLE, 64'd101);
    acc(CSR_RW, CSR_MCYCLE, 64'hFFFF_FFFF_FFFF_FFFF);
    expect_val("mcyc_pre", SIG_RD, 64'd102); check();
    rd_chk("mcyc_max", CSR_MCYCLE, 64'hFFFF_FFFF_FFFF_FFFF);
    rd_chk("mcyc_wrap", CSR_MCYCLE, 64'h0);
    rd_chk("minstret0", CSR_INSTRET, 64'h0);
    rd_chk("mip", CSR_MIP, 64'h0);

    // Trap entry with a concurrent mscratch write, then MRET.
    acc(CSR_RS, CSR_MSTATUS, 64'h8);
    expect_val("mst_init", SIG_RD, 64'h1800); check();
    rd_chk("mst_mie", CSR_MSTATUS, 64'h1808);
    expect_val("mieg_set", SIG_MIEG, 64'h1); check();
    acc(CSR_RW, CSR_MSCRATCH, 64'hDEAD);
    trap = 1'b1; trap_pc = 64'h8000_0102; trap_cause = 64'hB; trap_val = 64'h77;
    #1;
    expect_val("tvec_direct", SIG_TVEC, MTVEC); check();
    rd_chk("mepc", CSR_MEPC, 64'h8000_0100);
    expect_val("mepc_port", SIG_MEPC, 64'h8000_0100); check();
    rd_chk("mcause", CSR_MCAUSE, 64'hB);
    rd_chk("mtval", CSR_MTVAL, 64'h77);
    rd_chk("mst_trap", CSR_MSTATUS, 64'h1880);
    expect_val("mieg_trap", SIG_MIEG, 64'h0); check();
    rd_chk("mscr_keep", CSR_MSCRATCH, 64'hF1230);
    slot(); mret = 1'b1; #1;
    rd_chk("mst_mret", CSR_MSTATUS, 64'h1888);
    expect_val("mieg_mret", SIG_MIEG, 64'h1); check();

    // Vectored mode and reserved-mode write.
    acc(CSR_RW, CSR_MTVEC, 64'h8000_0001);
    acc(CSR_RS, CSR_MTVEC, 64'h0);
    trap_cause = 64'h8000_0000_0000_0007; #1;
    expect_val("mtvec_vec", SIG_RD, 64'h8000_0001);
    expect_val("tvec_irq", SIG_TVEC, 64'h8000_001C); check();
    trap_cause = 64'h2; #1;
    expect_val("tvec_exc", SIG_TVEC, 64'h8000_0000); check();
    acc(CSR_RW, CSR_MTVEC, 64'h8000_0003);
    trap_cause = 64'h8000_0000_0000_0007;
    rd_chk("mtvec_mode3", CSR_MTVEC, 64'h8000_0000);
    expect_val("tvec_mode3", SIG_TVEC, 64'h8000_0000); check();

    // minstret: ten retirements, overwritten on the fifth.
    for (int i = 1; i <= 10; i++) begin
      if (i == 5) acc(CSR_RW, CSR_MINSTRET, 64'd1000);
      else        acc(CSR_RS, CSR_INSTRET, 64'h0);
      retire = 1'b1; #1;
      expect_val($sformatf("retire_%0d", i), SIG_RD,
                 (i <= 5) ? 64'(i - 1) : 64'(1000 + i - 6));
      check();
    end
    rd_chk("minstret_end", CSR_MINSTRET, 64'd1005);

    // Asynchronous reset in the middle of a pending write and trap.
    acc(CSR_RW, CSR_MSCRATCH, 64'h55);
    trap = 1'b1; trap_pc = 64'h4000; #1;
    rst_n = 1'b0; #1;
    expect_val("arst_mscr", SIG_RD, 64'h0);
    expect_val("arst_mepc", SIG_MEPC, 64'h0);
    expect_val("arst_mieg", SIG_MIEG, 64'h0);
    expect_val("arst_tvec", SIG_TVEC, MTVEC); check();
    a = CSR_MINSTRET; #1;
    expect_val("arst_minst", SIG_RD, 64'h0); check();
    a = CSR_MCYCLE; #1;
    expect_val("arst_mcyc", SIG_RD, 64'h0); check();
    @(posedge clk); #1;
    a = CSR_MSCRATCH; #1;
    expect_val("arst_hold", SIG_RD, 64'h0); check();
    @(negedge clk);
    rst_n = 1'b1;
    rd_chk("post_rst_mst", CSR_MSTATUS, 64'h1800);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
